// File: rtl/auto_load_seq_pkg.sv
// Shared types and constants for the parametrised flash auto-loader.
package al_pkg;

  // Sequencer states; one word walks ISSUE..NEXT.
  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_ISSUE     = 4'd1,
    S_WAIT_BUSY = 4'd2,
    S_WAIT_DONE = 4'd3,
    S_CAPTURE   = 4'd4,
    S_CLR       = 4'd5,
    S_NEXT      = 4'd6,
    S_FIN       = 4'd7,
    S_ABORTED   = 4'd8
  } al_state_e;

  // Command word and engine opcode for a read-array transaction.
  localparam logic [15:0] READ_ARRAY_CMD = 16'h00FF;
  localparam logic [1:0]  OP_READ        = 2'b10;

  // AL_STATUS bit positions.
  localparam int unsigned ST_ACTIVE    = 0;
  localparam int unsigned ST_COMPLETED = 1;
  localparam int unsigned ST_ABORTED   = 2;
  localparam int unsigned ST_TIMEOUT   = 3;

  // Bits needed to hold 0..max_val, never less than one.
  function automatic int unsigned width_of(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/auto_load_seq_if.sv
// Bus between the auto-loader, the shared command engine and the register file.
interface auto_load_seq_if #(
  parameter int ADDR_W = 23,
  parameter int DATA_W = 16,
  parameter int CNT_W  = 6
);
  // control and engine response
  logic              START;
  logic              ABORT;
  logic [CNT_W:0]    LEN_OVR;
  logic              BUSY;
  logic              DONE;
  logic [DATA_W-1:0] RD_DATA;
  // engine command side
  logic [ADDR_W-1:0] AL_ADDR;
  logic [DATA_W-1:0] AL_CMD_DATA_OUT;
  logic [1:0]        AL_OP;
  logic              AL_EXECUTE;
  logic              CLR_DONE;
  logic              AL_ENA;
  // register-file write port and status
  logic              WR_EN;
  logic [CNT_W-1:0]  WR_ADDR;
  logic [DATA_W-1:0] WR_DATA;
  logic [CNT_W:0]    AL_CNT;
  logic [3:0]        AL_STATUS;

  // the sequencer
  modport master (
    input  START, ABORT, LEN_OVR, BUSY, DONE, RD_DATA,
    output AL_ADDR, AL_CMD_DATA_OUT, AL_OP, AL_EXECUTE, CLR_DONE, AL_ENA,
           WR_EN, WR_ADDR, WR_DATA, AL_CNT, AL_STATUS
  );

  // engine / control environment
  modport slave (
    output START, ABORT, LEN_OVR, BUSY, DONE, RD_DATA,
    input  AL_ADDR, AL_CMD_DATA_OUT, AL_OP, AL_EXECUTE, CLR_DONE, AL_ENA,
           WR_EN, WR_ADDR, WR_DATA, AL_CNT, AL_STATUS
  );
endinterface

// File: rtl/al_timeout_ctr.sv
// Loadable down-counter; zero_o flags expiry and the count parks at zero.
module al_timeout_ctr #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         zero_o
);
  logic [W-1:0] cnt_q, cnt_d;

  // load wins over counting; counting stops at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load_i)                    cnt_d = load_val_i;
    else if (en_i && cnt_q != '0)  cnt_d = cnt_q - 1'b1;
  end

  // count register
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/auto_load_seq.sv
// Flash parameter-block auto-loader: reads len words through the shared
// command engine and writes them into the constant register file, with
// per-word timeout/retry, external abort and a sticky status word.
module auto_load_seq
  import al_pkg::*;
#(
  parameter int              ADDR_W    = 23,
  parameter int              DATA_W    = 16,
  parameter int              CNT_W     = 6,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 23'h7FC000,
  parameter int              N_WORDS   = 64,
  parameter int              TMO_CYC   = 1023,
  parameter int              MAX_RETRY = 2
) (
  input logic              CLK,
  input logic              RST_N,
  auto_load_seq_if.master  bus
);
  localparam int TW = width_of(TMO_CYC);
  localparam int RW = width_of(MAX_RETRY);
  localparam logic [TW-1:0]  TMO_LOAD = TW'(TMO_CYC);
  localparam logic [RW-1:0]  RETRY_MX = RW'(MAX_RETRY);
  localparam logic [CNT_W:0] LEN_DEF  = (CNT_W+1)'(N_WORDS);
  localparam logic [CNT_W:0] LEN_MAX  = {1'b1, {CNT_W{1'b0}}};

  al_state_e         state_q, state_d;
  logic [CNT_W-1:0]  offset_q, offset_d;
  logic [CNT_W:0]    cnt_q, cnt_d;
  logic [CNT_W:0]    len_q, len_d;
  logic [RW-1:0]     retry_q, retry_d;
  logic [3:0]        status_q, status_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic tmr_load, tmr_en, tmr_zero;
  logic retry_clr;

  al_timeout_ctr #(.W(TW)) u_tmo (
    .clk        (CLK),
    .rst_n      (RST_N),
    .load_i     (tmr_load),
    .load_val_i (TMO_LOAD),
    .en_i       (tmr_en),
    .zero_o     (tmr_zero)
  );

  // next-state and datapath updates; ABORT overrides everything but IDLE
  always_comb begin
    state_d   = state_q;
    offset_d  = offset_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    retry_d   = retry_q;
    status_d  = status_q;
    wdata_d   = wdata_q;
    tmr_load  = 1'b0;
    tmr_en    = 1'b0;
    retry_clr = 1'b0;

    case (state_q)
      S_IDLE: begin
        // a coincident ABORT is simply not looked at here
        if (bus.START) begin
          if (bus.LEN_OVR == '0)          len_d = LEN_DEF;
          else if (bus.LEN_OVR > LEN_MAX) len_d = LEN_MAX;
          else                            len_d = bus.LEN_OVR;
          offset_d               = '0;
          cnt_d                  = '0;
          retry_d                = '0;
          status_d[ST_COMPLETED] = 1'b0;
          status_d[ST_ABORTED]   = 1'b0;
          status_d[ST_ACTIVE]    = 1'b1;
          state_d                = S_ISSUE;
        end
      end
      S_ISSUE: begin
        tmr_load = 1'b1;
        state_d  = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        tmr_en = 1'b1;
        // a fast engine may already report DONE without showing BUSY
        if (bus.BUSY || bus.DONE) state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        tmr_en = 1'b1;
        if (bus.DONE) begin
          wdata_d = bus.RD_DATA;
          state_d = S_CAPTURE;
        end else if (tmr_zero) begin
          status_d[ST_TIMEOUT] = 1'b1;
          if (retry_q < RETRY_MX) begin
            retry_d   = retry_q + 1'b1;
            retry_clr = 1'b1;
            state_d   = S_ISSUE;
          end else begin
            state_d = S_ABORTED;
          end
        end
      end
      S_CAPTURE: begin
        cnt_d   = cnt_q + 1'b1;
        state_d = S_CLR;
      end
      S_CLR: begin
        retry_d = '0;
        state_d = S_NEXT;
      end
      S_NEXT: begin
        // len is clamped to 2**CNT_W, so offset never needs to wrap
        if (cnt_q == len_q) begin
          state_d = S_FIN;
        end else begin
          offset_d = offset_q + 1'b1;
          state_d  = S_ISSUE;
        end
      end
      S_FIN: begin
        status_d[ST_COMPLETED] = 1'b1;
        status_d[ST_ACTIVE]    = 1'b0;
        state_d                = S_IDLE;
      end
      S_ABORTED: begin
        status_d[ST_ABORTED] = 1'b1;
        status_d[ST_ACTIVE]  = 1'b0;
        state_d              = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // abort wins over DONE and timeout; a word already written stays counted
    if (bus.ABORT && state_q != S_IDLE && state_q != S_ABORTED) begin
      state_d   = S_ABORTED;
      offset_d  = offset_q;
      retry_d   = retry_q;
      status_d  = status_q;
      wdata_d   = wdata_q;
      retry_clr = 1'b0;
    end
  end

  // state and datapath registers
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q  <= S_IDLE;
      offset_q <= '0;
      cnt_q    <= '0;
      len_q    <= '0;
      retry_q  <= '0;
      status_q <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      offset_q <= offset_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      retry_q  <= retry_d;
      status_q <= status_d;
      wdata_q  <= wdata_d;
    end
  end

  // strobes decode from the registered state; CLR_DONE also fires on a retry
  assign bus.AL_EXECUTE      = (state_q == S_ISSUE);
  assign bus.WR_EN           = (state_q == S_CAPTURE);
  assign bus.CLR_DONE        = (state_q == S_CLR) || (state_q == S_ABORTED) || retry_clr;
  assign bus.AL_ENA          = (state_q != S_IDLE);
  assign bus.AL_ADDR         = {BASE_ADDR[ADDR_W-1:CNT_W], offset_q};
  assign bus.AL_CMD_DATA_OUT = DATA_W'(READ_ARRAY_CMD);
  assign bus.AL_OP           = OP_READ;
  assign bus.WR_ADDR         = offset_q;
  assign bus.WR_DATA         = wdata_q;
  assign bus.AL_CNT          = cnt_q;
  assign bus.AL_STATUS       = status_q;
endmodule

// File: tb/tb_auto_load_seq.sv
// Bench for auto_load_seq: a behavioural command engine, a word-level
// reference model, a table of directed loads, reset/restart and random loads.
module tb_auto_load_seq;
  localparam int CNT_W = 6;
  localparam int AW    = 23;
  localparam int DW    = 16;
  localparam int MAXR  = 2;
  localparam int TMO   = 100;
  localparam int NONE  = 1000;
  localparam int BASE  = 'h7FC000;

  logic CLK = 1'b0;
  logic RST_N;
  always #5 CLK = ~CLK;

  auto_load_seq_if #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CNT_W)) bus ();

  auto_load_seq #(
    .ADDR_W(AW), .DATA_W(DW), .CNT_W(CNT_W), .BASE_ADDR(23'h7FC000),
    .N_WORDS(64), .TMO_CYC(TMO), .MAX_RETRY(MAXR)
  ) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus.master)
  );

  int n_chk = 0;
  int n_pass = 0;

  // engine behaviour knobs
  int dly;
  int drop_w = NONE;
  int drop_att;
  int abort_w = NONE;
  int att [64];
  logic [15:0] mem [64];

  // observed and expected traffic
  int wr_q[$], ex_q[$], clr_n;
  int exp_wr[$], exp_ex[$], exp_clr, exp_cnt;
  logic [3:0] exp_st;
  bit m_tmo = 1'b0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Word-level model: each word is tried until answered or retries run out,
  // an external abort lands on the cycle its DONE would have appeared.
  task automatic model(input int ovr, input int dw, input int da, input int aw);
    int len, tries, a;
    bit ab;
    len = (ovr == 0) ? 64 : ((ovr > 64) ? 64 : ovr);
    exp_wr.delete(); exp_ex.delete(); exp_clr = 0; ab = 1'b0;
    for (int w = 0; w < len; w++) begin
      a = (w == dw) ? da : 0;
      tries = (a > MAXR) ? MAXR + 1 : a + 1;
      for (int t = 0; t < tries; t++) exp_ex.push_back(BASE + w);
      exp_clr += tries - 1;
      if (a > 0) m_tmo = 1'b1;
      if (a > MAXR) begin ab = 1'b1; exp_clr++; break; end
      if (w == aw)  begin ab = 1'b1; exp_clr++; break; end
      exp_wr.push_back((w << 16) | int'(mem[w]));
      exp_clr++;
    end
    exp_cnt = exp_wr.size();
    exp_st  = {m_tmo, ab, ~ab, 1'b0};
  endtask

  // Engine + monitor: record strobes at negedge, react just after posedge.
  initial begin
    bit s_ex, s_clr, pend, drop;
    logic [AW-1:0] s_addr;
    int tick, off;
    pend = 0; drop = 0; tick = 0; off = 0;
    forever begin
      @(negedge CLK);
      s_ex = bus.AL_EXECUTE; s_clr = bus.CLR_DONE; s_addr = bus.AL_ADDR;
      if (bus.WR_EN)      wr_q.push_back(int'({bus.WR_ADDR, bus.WR_DATA}));
      if (bus.AL_EXECUTE) ex_q.push_back(int'(bus.AL_ADDR));
      if (bus.CLR_DONE)   clr_n++;
      @(posedge CLK); #1;
      bus.ABORT = 1'b0;
      if (!RST_N) begin
        bus.BUSY = 1'b0; bus.DONE = 1'b0; pend = 0;
      end else begin
        if (s_clr) begin bus.DONE = 1'b0; bus.BUSY = 1'b0; pend = 0; end
        if (s_ex) begin
          off  = int'(s_addr[CNT_W-1:0]);
          drop = (off == drop_w) && (att[off] < drop_att);
          att[off]++;
          pend = 1; tick = dly;
        end
        if (pend) begin
          if (tick == 0) begin
            pend = 0;
            if (drop) bus.BUSY = 1'b1;
            else begin
              bus.BUSY = 1'b0; bus.DONE = 1'b1; bus.RD_DATA = mem[off];
              if (off == abort_w) bus.ABORT = 1'b1;
            end
          end else begin
            bus.BUSY = 1'b1; tick--;
          end
        end
      end
      if (!bus.DONE) bus.RD_DATA = 16'hDEAD;
    end
  end

  task automatic run_load(input int ovr, input int d, input int dw, input int da,
                          input int aw, input bit sab, input bit mid,
                          output int acnt, output logic [3:0] ast);
    int cyc;
    dly = d; drop_w = dw; drop_att = da; abort_w = aw;
    for (int i = 0; i < 64; i++) begin att[i] = 0; mem[i] = 16'($urandom); end
    wr_q.delete(); ex_q.delete(); clr_n = 0;
    model(ovr, dw, da, aw);
    @(negedge CLK);
    chk("ena_idle_before", bus.AL_ENA, 0);
    bus.LEN_OVR = (CNT_W+1)'(ovr); bus.START = 1'b1; bus.ABORT = sab;
    @(negedge CLK);
    bus.START = 1'b0; bus.ABORT = 1'b0;
    chk("ena_rise", bus.AL_ENA, 1);
    cyc = 0;
    while (bus.AL_ENA && cyc < 30000) begin
      @(negedge CLK);
      cyc++;
      bus.START = (mid && cyc == 25);
    end
    bus.START = 1'b0;
    chk("load_terminates", (cyc < 30000), 1);
    chk("wr_count", wr_q.size(), exp_wr.size());
    for (int i = 0; i < exp_wr.size(); i++)
      chk("wr_addr_data", (i < wr_q.size()) ? wr_q[i] : -1, exp_wr[i]);
    chk("exec_count", ex_q.size(), exp_ex.size());
    for (int i = 0; i < exp_ex.size(); i++)
      chk("exec_addr", (i < ex_q.size()) ? ex_q[i] : -1, exp_ex[i]);
    chk("clr_done_count", clr_n, exp_clr);
    chk("al_cnt_model", bus.AL_CNT, exp_cnt);
    chk("status_model", bus.AL_STATUS, exp_st);
    acnt = int'(bus.AL_CNT); ast = bus.AL_STATUS;
  endtask

  typedef struct {
    int ovr; int dly; int dw; int da; int aw; bit sab;
    int cnt; logic [3:0] st;
  } vec_t;
  vec_t tbl [8];

  initial begin
    int acnt, cyc;
    logic [3:0] ast;
    RST_N = 1'b0;
    bus.START = 0; bus.ABORT = 0; bus.LEN_OVR = '0;
    bus.BUSY = 0; bus.DONE = 0; bus.RD_DATA = '0;
    repeat (3) @(negedge CLK);
    chk("rst_ena", bus.AL_ENA, 0);
    chk("rst_exec", bus.AL_EXECUTE, 0);
    chk("rst_wr_en", bus.WR_EN, 0);
    chk("rst_clr_done", bus.CLR_DONE, 0);
    chk("rst_cnt", bus.AL_CNT, 0);
    chk("rst_status", bus.AL_STATUS, 0);
    chk("rst_cmd", bus.AL_CMD_DATA_OUT, 'h00FF);
    chk("rst_op", bus.AL_OP, 2);
    RST_N = 1'b1;

    //          ovr  dly dw    da  aw    sab  cnt st
    tbl[0] = '{0,   3,  NONE, 0,  NONE, 1'b0, 64, 4'b0010};
    tbl[1] = '{5,   3,  NONE, 0,  NONE, 1'b1, 5,  4'b0010};
    tbl[2] = '{100, 2,  NONE, 0,  NONE, 1'b0, 64, 4'b0010};
    tbl[3] = '{64,  1,  NONE, 0,  NONE, 1'b0, 64, 4'b0010};
    tbl[4] = '{8,   0,  NONE, 0,  NONE, 1'b0, 8,  4'b0010};
    tbl[5] = '{0,   3,  NONE, 0,  10,   1'b0, 10, 4'b0100};
    tbl[6] = '{0,   3,  7,    1,  NONE, 1'b0, 64, 4'b1010};
    tbl[7] = '{0,   3,  3,    99, NONE, 1'b0, 3,  4'b1100};
    for (int i = 0; i < 8; i++) begin
      run_load(tbl[i].ovr, tbl[i].dly, tbl[i].dw, tbl[i].da, tbl[i].aw,
               tbl[i].sab, 1'b0, acnt, ast);
      chk("tbl_cnt", acnt, tbl[i].cnt);
      chk("tbl_status", ast, tbl[i].st);
    end

    // reset in the middle of WAIT_DONE, then a clean restart
    dly = 30; drop_w = NONE; abort_w = NONE; ex_q.delete();
    @(negedge CLK); bus.LEN_OVR = '0; bus.START = 1'b1;
    @(negedge CLK); bus.START = 1'b0;
    cyc = 0;
    while (ex_q.size() < 2 && cyc < 2000) begin @(negedge CLK); cyc++; end
    chk("rst_seq_reached_word1", ex_q.size(), 2);
    repeat (5) @(negedge CLK);
    chk("rst_seq_active", bus.AL_STATUS, 4'b1001);
    RST_N = 1'b0;
    @(negedge CLK);
    chk("midrst_ena", bus.AL_ENA, 0);
    chk("midrst_exec", bus.AL_EXECUTE, 0);
    chk("midrst_clr", bus.CLR_DONE, 0);
    chk("midrst_wr_en", bus.WR_EN, 0);
    chk("midrst_cnt", bus.AL_CNT, 0);
    chk("midrst_status", bus.AL_STATUS, 0);
    chk("midrst_wr_addr", bus.WR_ADDR, 0);
    chk("midrst_addr", bus.AL_ADDR, BASE);
    RST_N = 1'b1; m_tmo = 1'b0; ex_q.delete();
    repeat (40) @(negedge CLK);
    chk("no_exec_after_rst", ex_q.size(), 0);
    run_load(0, 2, NONE, 0, NONE, 1'b0, 1'b1, acnt, ast);
    chk("restart_cnt", acnt, 64);
    chk("restart_status", ast, 4'b0010);

    // random loads against the model
    for (int r = 0; r < 10; r++) begin
      int ovr, d, dw, da, aw;
      ovr = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 127));
      d   = int'($urandom_range(0, 4));
      dw  = int'($urandom_range(0, 99));
      da  = int'($urandom_range(0, 3));
      aw  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 70)) : NONE;
      run_load(ovr, d, dw, da, aw, 1'b0, 1'b0, acnt, ast);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
